pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage that feeds the CPU's 2:1 next-PC mux path.
- Holds the current PC and computes the sequential address (PC+STEP) internally.
- Selects between that address and a branch target, using the same select semantics as the team's mux: 0 = sequential, 1 = branch.
- Issues req/ack fetches to instruction memory and presents each fetched instruction to decode with a held-valid protocol.

Parameters:
ADDR_W, 32, PC and fetch address width
DATA_W, 32, instruction width
RESET_VEC, 0, PC value loaded on reset
STEP, 4, sequential increment; must be a power of two

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; when low, no new fetch is issued
stall  input  1  decode back-pressure; while high, a presented instruction is held
branch_taken  input  1  redirect request, sampled at posedge
branch_target  input  ADDR_W  redirect address
fetch_req  output  1  fetch request to instruction memory
fetch_addr  output  ADDR_W  fetch address
fetch_ack  input  1  memory completion
fetch_data  input  DATA_W  instruction; valid while fetch_ack=1
instr_valid  output  1  instr_out is valid for decode
instr_out  output  DATA_W  fetched instruction
instr_pc  output  ADDR_W  address of instr_out
next_pc_sel  output  1  registered select used for the last PC update (0 = PC+STEP, 1 = target)

Behaviour:
- Interface: one clock domain, clk. rst is asynchronous and active-high.
- Reset (async assert, any state): state=IDLE, pc=RESET_VEC. fetch_req=0, fetch_addr=RESET_VEC, instr_valid=0, instr_out=0, instr_pc=0, next_pc_sel=0, redirect_pending=0.
- All outputs are registered. fetch_addr always equals pc.
- Sequential next PC = (pc+STEP) mod 2^ADDR_W; 2^ADDR_W−STEP wraps to 0.
- branch_target is aligned to STEP by clearing its low log2(STEP) bits before use.
- IDLE state:
  - fetch_req=0.
  - branch_taken: pc<=aligned target, next_pc_sel<=1.
  - en=1 and stall=0 and branch_taken=0: go to REQ. fetch_req is high starting the next cycle.
- REQ state:
  - fetch_req=1. fetch_addr is held stable until fetch_ack.
  - stall never withdraws the request.
  - branch_taken without ack: latch redirect_pending=1 and the aligned target. Request stays outstanding.
  - Normal ack (no redirect pending, no branch this cycle): instr_out<=fetch_data, instr_pc<=pc, instr_valid<=1, pc<=pc+STEP, next_pc_sel<=0, go to HOLD.
  - Ack with branch_taken this cycle or redirect_pending: data discarded (instr_valid stays 0), pc<=target, next_pc_sel<=1, redirect_pending<=0. Then go to REQ if en=1, else IDLE.
  - If branch_taken and redirect_pending coincide, the current branch_target wins.
- HOLD state:
  - instr_valid=1; instr_out and instr_pc are held while stall=1.
  - stall=0: the instruction is consumed. instr_valid<=0, then go to REQ if en=1, else IDLE.
  - branch_taken (overrides stall): instr_valid<=0, pc<=target, next_pc_sel<=1, then go to REQ if en=1, else IDLE.
- Throughput with zero-wait memory:
  - ack arrives in the first REQ cycle; instr_valid is high the next cycle.
  - Steady state gives 1 instruction per 2 cycles (REQ then HOLD).
- en dropping during REQ does not cancel the fetch. It only prevents the next request.
- Memory contract: fetch_ack asserted without fetch_req is ignored.

Optional Feature:
PC_TRACE_EN
- Defined:
  - Adds output fetch_count [31:0]. It increments on every cycle where instr_valid=1 and stall=0 and there is no branch.
  - Adds output redirect_count [15:0]. It increments on every applied redirect.
  - Both reset to 0 and wrap modulo 2^width.
- Undefined: both ports and their counters are absent. Remaining behaviour is identical.

Test Plan:
- Reset release, en=1, ack one cycle after each req → fetch_addr sequence 0x0,0x4,0x8. instr_valid pulses carry the matching data; instr_pc equals the fetch address.
- In HOLD with instr_out=0x00A00093, hold stall=1 for 3 cycles → instr_out/instr_valid stable. No new fetch_req until the cycle after stall=0.
- branch_taken with target 0x103 while REQ is outstanding, ack 2 cycles later → that data is discarded (instr_valid=0). Next fetch_addr=0x100, next_pc_sel=1.
- pc=0xFFFFFFFC, ack → pc wraps to 0x00000000, next_pc_sel=0.
- Assert rst mid-REQ with fetch_req=1 → outputs drop asynchronously: fetch_req=0, fetch_addr=RESET_VEC, instr_valid=0.
- With PC_TRACE_EN: 5 consumed fetches and 2 redirects → fetch_count=5, redirect_count=2. Without the macro, the bench compiles without these ports.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack fetch sequencer with held-valid handoff to decode.
// Define PC_TRACE_EN to add the fetch_count/redirect_count trace counters.
module pc_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int STEP = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic stall,
   input  logic branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic fetch_req,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic fetch_ack,
   input  logic [DATA_W-1:0] fetch_data,
   output logic instr_valid,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic next_pc_sel
`ifdef PC_TRACE_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] redirect_count
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);
   state_t state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, tgt, pend_tgt, redir_pc;
   logic pend, ack_ok, take, redir, sel_nx;
   assign fetch_addr = pc;
   assign tgt = branch_target & ALIGN_MASK;
   assign ack_ok = (state == REQ) && fetch_ack;
   assign take = ack_ok && !branch_taken && !pend;
   // a redirect seen mid-request only takes effect when that request completes
   assign redir = (branch_taken && state != REQ) || (ack_ok && (branch_taken || pend));
   assign redir_pc = branch_taken ? tgt : pend_tgt;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = (!branch_taken && en && !stall) ? REQ : IDLE;
         REQ: state_nx = !fetch_ack ? REQ : take ? HOLD : en ? REQ : IDLE;
         HOLD: state_nx = (branch_taken || !stall) ? (en ? REQ : IDLE) : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      pc_nx = redir ? redir_pc : take ? pc + ADDR_W'(STEP) : pc;
      sel_nx = redir ? 1'b1 : take ? 1'b0 : next_pc_sel;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc <= RESET_VEC;
         fetch_req <= 1'b0;
         instr_valid <= 1'b0;
         instr_out <= '0;
         instr_pc <= '0;
         next_pc_sel <= 1'b0;
         pend <= 1'b0;
         pend_tgt <= '0;
      end else begin
         pc <= pc_nx;
         next_pc_sel <= sel_nx;
         fetch_req <= state_nx == REQ;
         instr_valid <= state_nx == HOLD;
         if (take) begin
            instr_out <= fetch_data;
            instr_pc <= pc;
         end
         pend <= (state == REQ) && !fetch_ack && (pend || branch_taken);
         if (state == REQ && !fetch_ack && branch_taken) pend_tgt <= tgt;
      end
`ifdef PC_TRACE_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fetch_count <= '0;
         redirect_count <= '0;
      end else begin
         if (instr_valid && !stall && !branch_taken) fetch_count <= fetch_count + 32'd1;
         if (redir) redirect_count <= redirect_count + 16'd1;
      end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random stimulus for pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;
   localparam int AW = 32, DW = 32, STEP = 4;
   logic clk = 0, rst = 1, en = 0, stall = 0, branch_taken = 0, fetch_ack = 0;
   logic [AW-1:0] branch_target = '0;
   logic [DW-1:0] fetch_data = '0;
   logic fetch_req, instr_valid, next_pc_sel;
   logic [AW-1:0] fetch_addr, instr_pc;
   logic [DW-1:0] instr_out;
`ifdef PC_TRACE_EN
   logic [31:0] fetch_count;
   logic [15:0] redirect_count;
`endif
   int checks = 0, failures = 0;
   logic [AW-1:0] m_pc, m_ipc, m_ptgt;
   logic [DW-1:0] m_out;
   logic m_req, m_valid, m_sel, m_pend;
   logic [31:0] m_fc;
   logic [15:0] m_rc;
   pc_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_VEC('0), .STEP(STEP)) dut (
      .clk(clk), .rst(rst), .en(en), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .fetch_data(fetch_data), .instr_valid(instr_valid),
      .instr_out(instr_out), .instr_pc(instr_pc), .next_pc_sel(next_pc_sel)
`ifdef PC_TRACE_EN
      , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_pc = '0; m_ipc = '0; m_ptgt = '0; m_out = '0;
      m_req = 0; m_valid = 0; m_sel = 0; m_pend = 0; m_fc = '0; m_rc = '0;
   endtask
   task automatic model(input logic e, input logic s, input logic b, input logic [AW-1:0] t,
                        input logic a, input logic [DW-1:0] d);
      logic [AW-1:0] al;
      al = t & ~AW'(STEP - 1);
      if (m_req) begin
         if (a) begin
            m_req = 0;
            if (b || m_pend) begin
               m_pc = b ? al : m_ptgt; m_sel = 1; m_pend = 0; m_rc++; m_req = e;
            end else begin
               m_out = d; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + AW'(STEP); m_sel = 0;
            end
         end else if (b) begin
            m_pend = 1; m_ptgt = al;
         end
      end else if (m_valid) begin
         if (b) begin
            m_valid = 0; m_pc = al; m_sel = 1; m_rc++; m_req = e;
         end else if (!s) begin
            m_valid = 0; m_fc++; m_req = e;
         end
      end else if (b) begin
         m_pc = al; m_sel = 1; m_rc++;
      end else if (e && !s) m_req = 1;
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".req"}, fetch_req, m_req);
      chk({tag, ".addr"}, fetch_addr, m_pc);
      chk({tag, ".valid"}, instr_valid, m_valid);
      chk({tag, ".sel"}, next_pc_sel, m_sel);
      if (m_valid) begin
         chk({tag, ".out"}, instr_out, m_out);
         chk({tag, ".ipc"}, instr_pc, m_ipc);
      end
`ifdef PC_TRACE_EN
      chk({tag, ".fcnt"}, fetch_count, m_fc);
      chk({tag, ".rcnt"}, redirect_count, m_rc);
`endif
   endtask
   task automatic step(input string tag, input logic e, input logic s, input logic b,
                       input logic [AW-1:0] t, input logic a, input logic [DW-1:0] d);
      en = e; stall = s; branch_taken = b; branch_target = t; fetch_ack = a; fetch_data = d;
      @(posedge clk);
      model(e, s, b, t, a, d);
      #1;
      check_all(tag);
   endtask
   initial begin
      model_reset();
      #12;
      check_all("reset");
      chk("reset.out", instr_out, 0);
      chk("reset.ipc", instr_pc, 0);
      rst = 0;
      step("start", 1, 0, 0, 0, 0, 0);
      chk("seq.addr0", fetch_addr, 32'h0);
      step("ack0", 1, 0, 0, 0, 1, 32'h11110000);
      chk("seq.data0", instr_out, 32'h11110000);
      step("cons0", 1, 0, 0, 0, 0, 0);
      chk("seq.addr1", fetch_addr, 32'h4);
      step("ack1", 1, 0, 0, 0, 1, 32'h22220004);
      chk("seq.ipc1", instr_pc, 32'h4);
      step("cons1", 1, 0, 0, 0, 0, 0);
      chk("seq.addr2", fetch_addr, 32'h8);
      step("ack2", 1, 0, 0, 0, 1, 32'h00A00093);
      for (int i = 0; i < 3; i++) begin
         step("stall", 1, 1, 0, 0, 0, $urandom);
         chk("stall.out", instr_out, 32'h00A00093);
         chk("stall.valid", instr_valid, 1);
         chk("stall.req", fetch_req, 0);
      end
      step("unstall", 1, 0, 0, 0, 0, 0);
      chk("unstall.req", fetch_req, 1);
      step("br_req", 1, 0, 1, 32'h103, 0, 0);
      step("br_wait", 1, 0, 0, 0, 0, 0);
      step("br_ack", 1, 0, 0, 0, 1, 32'hDEADBEEF);
      chk("br.valid", instr_valid, 0);
      chk("br.addr", fetch_addr, 32'h100);
      chk("br.sel", next_pc_sel, 1);
      step("wrap_br", 1, 0, 1, 32'hFFFFFFFE, 1, $urandom);
      chk("wrap.addr", fetch_addr, 32'hFFFFFFFC);
      step("wrap_ack", 1, 0, 0, 0, 1, 32'h0BADF00D);
      chk("wrap.pc", fetch_addr, 32'h0);
      chk("wrap.sel", next_pc_sel, 0);
      chk("wrap.ipc", instr_pc, 32'hFFFFFFFC);
      step("w_cons", 1, 0, 0, 0, 0, 0);
      step("w_ack", 1, 0, 0, 0, 1, $urandom);
      step("w_cons2", 1, 0, 0, 0, 0, 0);
      rst = 1;
      #1;
      chk("arst.req", fetch_req, 0);
      chk("arst.addr", fetch_addr, 32'h0);
      chk("arst.valid", instr_valid, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      step("t_start", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step("t_ack", 1, 0, 0, 0, 1, $urandom);
         step("t_cons", 1, 0, 0, 0, 0, 0);
      end
      step("t_br1", 1, 0, 1, 32'h200, 1, $urandom);
      step("t_br2", 0, 0, 1, 32'h300, 1, $urandom);
      chk("t.idle", fetch_req, 0);
`ifdef PC_TRACE_EN
      chk("trace.fetch_count", fetch_count, 5);
      chk("trace.redirect_count", redirect_count, 2);
`endif
      for (int i = 0; i < 2000; i++) begin
         logic a;
         a = m_req ? logic'($urandom_range(1, 0)) : ($urandom_range(9, 0) == 0);
         step("rand", $urandom_range(9, 0) != 0, $urandom_range(2, 0) == 0,
              $urandom_range(9, 0) == 0, $urandom, a, $urandom);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
